uart_rx_port: RTL and testbench
===============================

UART_RX_PORT -- requirements
Module: uart_rx_port

Interface
REQ-001 Parameter CLK_PER_BIT, default 16, SHALL set clock cycles per serial bit; legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set receive buffer entries; power of two, 2..16.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 rx  input  1  SHALL be the asynchronous serial line, 8N1, idle high, LSB first.
REQ-006 rd_arg  input  1  SHALL be the core's dequeue request.
REQ-007 rd_out  output  9  SHALL be {valid, data[7:0]}, for direct connection to the core's ext_uart_read_out.
REQ-008 overflow  output  1  SHALL be a sticky flag: a received byte was dropped because the buffer was full.
REQ-009 frame_err  output  1  SHALL pulse for one cycle per frame with a bad stop bit (or bad parity, see Configuration).

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer, reset value 1, before any use; synchronizer latency is 2 cycles.
REQ-011 The receive FSM SHALL have states IDLE, START, DATA, PARITY (macro only), STOP and WAIT_IDLE.
REQ-012 IDLE->START SHALL occur on a synchronized high-to-low transition; the bit counter loads CLK_PER_BIT/2 (integer divide).
REQ-013 In START at counter expiry the line SHALL be resampled: low -> DATA with counter CLK_PER_BIT; high -> IDLE (glitch rejected, no error).
REQ-014 In DATA one bit SHALL be sampled every CLK_PER_BIT cycles into a shift register, LSB first; after the 8th bit go to STOP (or PARITY).
REQ-015 In STOP the sample SHALL be: high -> push byte, then IDLE; low -> frame_err pulse, byte dropped, then WAIT_IDLE.
REQ-016 WAIT_IDLE SHALL return to IDLE only after a synchronized high is seen, so a held-low line (break) yields exactly one frame_err.
REQ-017 rd_out[8] SHALL equal "buffer non-empty"; rd_out[7:0] SHALL be the head entry, combinational from buffer state, 8'h00 when empty.
REQ-018 A pop SHALL occur on a cycle with rd_arg=1 and rd_out[8]=1; rd_arg while empty SHALL be ignored.
REQ-019 A pushed byte SHALL appear on rd_out the cycle after the stop-bit sample cycle (first-word latency 1).
REQ-020 Push into a full buffer SHALL be dropped and set overflow, unless a pop occurs in the same cycle, in which case both succeed.
REQ-021 Simultaneous push and pop on a non-full buffer SHALL leave occupancy unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-022 Bytes SHALL be delivered strictly in arrival order.

Reset
REQ-023 On RST_N low: FSM=IDLE, counters=0, buffer empty, overflow=0, frame_err=0, synchronizer=1, rd_out=9'h000, all asynchronously.
REQ-024 Reset asserted mid-frame SHALL discard the partial byte; after release a new frame SHALL be detected only from a fresh falling edge.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: frames SHALL be 8E1; PARITY state samples one bit after data; even-parity mismatch -> frame_err pulse, byte dropped, stop bit still consumed before IDLE.
REQ-026 Macro UART_RX_PARITY_EN undefined: PARITY state and logic SHALL not exist; frames are 8N1.

Verification
REQ-027 CLK_PER_BIT=16, send 8'hA5 8N1 -> rd_out=9'h1A5 from the cycle after the stop sample; rd_arg=1 one cycle -> rd_out=9'h000.
REQ-028 Send 5 bytes 01..05 with no pops, FIFO_DEPTH=4 -> overflow=1, buffer holds 01..04; pop one during the 5th stop-sample cycle in a rerun -> overflow stays 0, 02..05 held.
REQ-029 rx low pulse of 6 cycles (< CLK_PER_BIT/2) -> no push, no frame_err, FSM back to IDLE.
REQ-030 Send 8'h3C with stop bit 0, then hold rx low 100 cycles, then high, then send 8'h11 -> exactly one frame_err pulse, only 9'h111 delivered.
REQ-031 Assert RST_N low during data bit 4 of 8'hFF, release, send 8'h42 -> only 9'h142 delivered, overflow=0.
REQ-032 With UART_RX_PARITY_EN, send 8'h03 with parity 1 -> frame_err pulse, no push; with parity 0 -> 9'h103 delivered.

Source files
------------

// File: rtl/uart_rx_port_if.sv
// uart_rx_port_if: serial line, dequeue request and receive status between a UART receiver and its core.
interface uart_rx_port_if;
  logic       rx;
  logic       rd_arg;
  logic [8:0] rd_out;
  logic       overflow;
  logic       frame_err;
  modport master (output rx, rd_arg, input rd_out, overflow, frame_err);
  modport slave (input rx, rd_arg, output rd_out, overflow, frame_err);
endinterface

// File: rtl/uart_rx_port.sv
// uart_rx_port: 8N1 UART receiver feeding a small FIFO read as {valid, data}.
// Define UART_RX_PARITY_EN for 8E1 frames with even-parity checking.
module uart_rx_port #(
  parameter int CLK_PER_BIT = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input logic           CLK,
  input logic           RST_N,
  uart_rx_port_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam logic [15:0] FULL_BIT = 16'(CLK_PER_BIT);
  localparam logic [15:0] HALF_BIT = 16'(CLK_PER_BIT / 2);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  localparam state_t AFTER_DATA = PARITY;
  logic par_bad_q;
  logic par_bad;
  assign par_bad = par_bad_q;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  localparam state_t AFTER_DATA = STOP;
  logic par_bad;
  assign par_bad = 1'b0;
`endif
  state_t        state_q;
  logic [15:0]   cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          frame_err_q;
  logic [1:0]    sync_q, sync_d;
  logic          rx_prev_q, rx_prev_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          overflow_q, overflow_d;
  logic          rx_s, expire, push, pop, full, wr;
  logic [7:0]    mem [FIFO_DEPTH];
  assign rx_s   = sync_q[1];
  assign expire = cnt_q == 16'd1;
  // The byte is written at the end of the stop-sample cycle, so it is readable the next cycle.
  assign push   = state_q == STOP && expire && rx_s && !par_bad;
  always_comb begin
    sync_d     = {sync_q[0], bus.rx};
    rx_prev_d  = rx_s;
    pop        = bus.rd_arg && fill_q != '0;
    full       = fill_q == FW'(FIFO_DEPTH);
    wr         = push && (!full || pop);
    wp_d       = wp_q + AW'(wr);
    rp_d       = rp_q + AW'(pop);
    fill_d     = fill_q + FW'(wr) - FW'(pop);
    overflow_d = overflow_q || (push && !wr);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      wp_q       <= '0;
      rp_q       <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (wr) mem[wp_q] <= sh_q;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_prev_q && !rx_s) begin
            state_q <= START;
            cnt_q   <= HALF_BIT;
          end
        end
        START: begin
          if (!expire) cnt_q <= cnt_q - 16'd1;
          else begin
            state_q <= rx_s ? IDLE : DATA;
            cnt_q   <= rx_s ? 16'd0 : FULL_BIT;
            bit_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
          end
        end
        DATA: begin
          if (!expire) cnt_q <= cnt_q - 16'd1;
          else begin
            sh_q    <= {rx_s, sh_q[7:1]};
            cnt_q   <= FULL_BIT;
            bit_q   <= bit_q + 3'd1;
            state_q <= bit_q == 3'd7 ? AFTER_DATA : DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (!expire) cnt_q <= cnt_q - 16'd1;
          else begin
            par_bad_q   <= ^{sh_q, rx_s};
            frame_err_q <= ^{sh_q, rx_s};
            cnt_q       <= FULL_BIT;
            state_q     <= STOP;
          end
        end
`endif
        STOP: begin
          if (!expire) cnt_q <= cnt_q - 16'd1;
          else begin
            frame_err_q <= !rx_s && !par_bad;
            cnt_q       <= '0;
            state_q     <= rx_s ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: state_q <= rx_s ? IDLE : WAIT_IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.rd_out    = fill_q != '0 ? {1'b1, mem[rp_q]} : 9'h000;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx_port.sv
// tb_uart_rx_port: randomized and directed frames against a byte-level scoreboard of the UART receiver.
module tb_uart_rx_port;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Edges from the last clock before the start-bit fall to the stop-sample edge, minus one.
  localparam int STOP_EDGE = 3 + CPB / 2 + CPB * (NBITS - 1) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_rand = 1'b0;
  logic rd_man = 1'b0;
  logic exp_ovf = 1'b0;
  int tests = 0;
  int fails = 0;
  int ferr_cnt = 0;
  int exp_ferr = 0;
  logic [7:0] sb[$];
  always #5 clk = ~clk;
  uart_rx_port_if bus();
  uart_rx_port #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void expect_byte(input logic [7:0] b, input logic ok);
    if (!ok) exp_ferr++;
    else if (sb.size() < DEPTH) sb.push_back(b);
    else exp_ovf = 1'b1;
  endfunction
  always begin
    @(posedge clk);
    #2 bus.rd_arg = rd_rand ? 1'($urandom_range(0, 1)) : rd_man;
  end
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.rd_arg === 1'b1 && bus.rd_out[8] === 1'b1) begin
      if (sb.size() == 0) chk("pop_extra", {23'b0, bus.rd_out}, 32'h0);
      else chk("pop_data", {24'b0, bus.rd_out[7:0]}, {24'b0, sb.pop_front()});
    end
  end
  task automatic send(input logic [7:0] b, input logic stop, input logic pflip, input int hold);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop, ^b ^ pflip, b, 1'b0};
`else
    bits = {1'b1, stop | (pflip & 1'b0), b, 1'b0};
`endif
    for (int i = 0; i < NBITS; i++) begin
      @(posedge clk);
      #1 bus.rx = bits[i];
      repeat (CPB - 1) @(posedge clk);
    end
    if (!stop) repeat (hold) @(posedge clk);
    @(posedge clk);
    #1 bus.rx = 1'b1;
  endtask
  task automatic drain();
    @(posedge clk);
    #1 rd_man = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1 rd_man = 1'b0;
    repeat (2) @(negedge clk);
    chk("drain_left", sb.size(), 0);
    chk("drain_rdout", {23'b0, bus.rd_out}, 32'h0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdout", {23'b0, bus.rd_out}, 32'h0);
    chk("rst_ovf", {31'b0, bus.overflow}, 32'h0);
    chk("rst_ferr", {31'b0, bus.frame_err}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask
  initial begin
    logic [7:0] b;
    logic err, pf;
    bus.rx = 1'b1;
    do_reset();
    expect_byte(8'hA5, 1'b1);
    fork
      send(8'hA5, 1'b1, 1'b0, 0);
      begin
        @(negedge bus.rx);
        repeat (STOP_EDGE) @(posedge clk);
        @(negedge clk);
        chk("lat_before", {23'b0, bus.rd_out}, 32'h0);
        @(negedge clk);
        chk("lat_after", {23'b0, bus.rd_out}, 32'h1A5);
      end
    join
    @(posedge clk);
    #1 rd_man = 1'b1;
    @(posedge clk);
    #1 rd_man = 1'b0;
    @(negedge clk);
    chk("pop_one", {23'b0, bus.rd_out}, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      expect_byte(8'(i), 1'b1);
      send(8'(i), 1'b1, 1'b0, 0);
      repeat (5) @(posedge clk);
    end
    @(negedge clk);
    chk("ovf_set", {31'b0, bus.overflow}, {31'b0, exp_ovf});
    chk("ovf_head", {23'b0, bus.rd_out}, 32'h101);
    drain();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      expect_byte(8'(i), 1'b1);
      send(8'(i), 1'b1, 1'b0, 0);
      repeat (5) @(posedge clk);
    end
    sb.push_back(8'h05);
    fork
      send(8'h05, 1'b1, 1'b0, 0);
      begin
        @(negedge bus.rx);
        repeat (STOP_EDGE) @(posedge clk);
        #1 rd_man = 1'b1;
        @(posedge clk);
        #1 rd_man = 1'b0;
      end
    join
    @(negedge clk);
    chk("ovf_clear", {31'b0, bus.overflow}, 32'h0);
    chk("full_head", {23'b0, bus.rd_out}, 32'h102);
    drain();
    @(posedge clk);
    #1 bus.rx = 1'b0;
    repeat (6) @(posedge clk);
    #1 bus.rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("glitch_rdout", {23'b0, bus.rd_out}, 32'h0);
    chk("glitch_ferr", ferr_cnt, exp_ferr);
    expect_byte(8'h5A, 1'b1);
    send(8'h5A, 1'b1, 1'b0, 0);
    drain();
    expect_byte(8'h3C, 1'b0);
    send(8'h3C, 1'b0, 1'b0, 100);
    repeat (20) @(posedge clk);
    expect_byte(8'h11, 1'b1);
    send(8'h11, 1'b1, 1'b0, 0);
    repeat (5) @(posedge clk);
    chk("break_ferr", ferr_cnt, exp_ferr);
    drain();
    fork
      send(8'hFF, 1'b1, 1'b0, 0);
      begin
        @(negedge bus.rx);
        repeat (3 + CPB / 2 + CPB * 4 + 6) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    expect_byte(8'h42, 1'b1);
    send(8'h42, 1'b1, 1'b0, 0);
    repeat (5) @(negedge clk);
    chk("rstmid_ovf", {31'b0, bus.overflow}, 32'h0);
    chk("rstmid_head", {23'b0, bus.rd_out}, 32'h142);
    drain();
`ifdef UART_RX_PARITY_EN
    expect_byte(8'h03, 1'b0);
    send(8'h03, 1'b1, 1'b1, 0);
    repeat (5) @(posedge clk);
    expect_byte(8'h03, 1'b1);
    send(8'h03, 1'b1, 1'b0, 0);
    repeat (5) @(negedge clk);
    chk("par_head", {23'b0, bus.rd_out}, 32'h103);
    chk("par_ferr", ferr_cnt, exp_ferr);
    drain();
`endif
    rd_rand = 1'b1;
    repeat (24) begin
      b = 8'($urandom);
      err = $urandom_range(0, 7) == 0;
`ifdef UART_RX_PARITY_EN
      pf = !err && $urandom_range(0, 7) == 0;
`else
      pf = 1'b0;
`endif
      expect_byte(b, !err && !pf);
      send(b, !err, pf, err ? int'($urandom_range(0, 30)) : 0);
      repeat ($urandom_range(CPB, 40)) @(posedge clk);
    end
    rd_rand = 1'b0;
    repeat (10) @(posedge clk);
    drain();
    chk("rand_ferr", ferr_cnt, exp_ferr);
    chk("rand_ovf", {31'b0, bus.overflow}, {31'b0, exp_ovf});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
